jk_drive_counter: RTL
=====================

Name: jk_drive_counter

Overview:
- Modulo up/down counter that produces the J/K drive vectors for a bank of JK flip-flops clocked on the same clk.
- Each cycle it computes the desired next state, then derives j/k with a fixed excitation table. It also keeps its own state q, updated with the JK rule, so q mirrors an external bank wired to j/k.
- Includes a load handshake, a terminal-count pulse and an optional one-shot stop.

Parameters:
- WIDTH, 4, counter/JK bank width in bits.
- MODULO, 10, count range 0..MODULO-1; legal range 2 <= MODULO <= 2**WIDTH.
- ONESHOT, 0, 1 = stop in DONE after the first wrap; 0 = free-running wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load_valid  input  1  load request.
- load_data  input  WIDTH  load value.
- load_ready  output  1  load accepted when load_valid && load_ready at a rising edge.
- j  output  WIDTH  J drive, combinational from state and inputs.
- k  output  WIDTH  K drive, combinational from state and inputs.
- q  output  WIDTH  current count, registered.
- qn  output  WIDTH  always ~q.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high. All state updates on the rising edge of clk.
- While rst=1:
  - j=0 and k=all-ones, so an external bank clears on the same edge.
  - load_ready=0.
  - After the edge: q=0, qn=all-ones, tc=0, state=IDLE.
- Excitation table, per bit (current -> target : j,k). Fixed; no don't-cares:
  - 0->0 : 0,0
  - 0->1 : 1,0
  - 1->0 : 0,1
  - 1->1 : 0,0
- Register update: q_next = JK rule applied to (q, j, k). This equals the target by construction. When no transition occurs, target=q, so j=k=0.
- States: IDLE, RUN, DONE. load_ready=1 in IDLE and DONE; load_ready=0 in RUN and during rst.
- IDLE:
  - Load accepted: target = clip(load_data); stay in IDLE.
  - Otherwise en=1: go to RUN with no count on that edge.
  - Otherwise hold.
- RUN:
  - en=0: go to IDLE, hold.
  - en=1, up=1: target = q+1, or 0 when q==MODULO-1 (wrap).
  - en=1, up=0: target = q-1, or MODULO-1 when q==0 (wrap).
  - On a wrap edge: tc=1 for exactly the following cycle. If ONESHOT=1, go to DONE.
- DONE:
  - Hold q.
  - Load accepted: go to IDLE with the loaded value.
  - Otherwise en=0: go to IDLE.
- clip(x): x if x < MODULO, else MODULO-1.
- Load priority:
  - A load never produces tc, even when the loaded value equals the wrap value.
  - Load overrides en in IDLE/DONE.
- Latency:
  - q reflects a count or load one edge after the enabling cycle.
  - tc is high in the cycle after the wrap edge.
  - First count after leaving IDLE occurs on the second en=1 edge.
- Direction change mid-run: takes effect on the same edge; no extra state.
- Reset mid-operation: overrides everything on that edge, including a pending load and a tc pulse.
- Width: arithmetic is WIDTH bits. Wrap is detected by compare against MODULO-1/0, never by overflow.

Optional Feature:
- JK_SELFCHECK_EN defined:
  - Adds input fb_q[WIDTH], the external bank's Q.
  - Adds output err (1 bit), registered and sticky.
  - err sets on any edge where rst=0 and fb_q != q sampled at that edge.
  - err clears only by rst; reset value 0.
- Not defined: fb_q and err ports are absent; no compare logic.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0.
  - During rst: j=0, k=4'hF, load_ready=0.
  - After: q=0, qn=4'hF, tc=0, load_ready=1.
- Up count (WIDTH=4, MODULO=10, ONESHOT=0): en=1, up=1 from q=0.
  - Cycle 1 IDLE->RUN; q then steps 1..9,0.
  - tc=1 only in the cycle after 9->0.
  - On the 7->8 edge: j=4'b1000, k=4'b0111.
- Down wrap: load 0, en=1, up=0.
  - q steps 0->9; tc pulses once.
  - On that edge: j=4'b1001, k=0.
- Load clip and handshake:
  - In IDLE, load_valid=1, load_data=4'd13: q becomes 9, no tc.
  - In RUN, load_valid=1: load_ready=0, q keeps counting, load ignored.
- ONESHOT=1: count up from 8 with en=1.
  - q goes 9, then 0; state DONE, q holds 0, tc one cycle.
  - Load 5 in DONE: q=5, state IDLE.
- Reset mid-run: rst=1 while q=6 in RUN and load_valid=1.
  - Next cycle q=0, tc=0, state IDLE.
  - With JK_SELFCHECK_EN: drive fb_q=q^1 for one cycle -> err=1 stays until rst.

Source files
------------

// File: rtl/jk_drive_counter.sv
// jk_drive_counter: modulo up/down counter emitting JK excitation vectors; `JK_SELFCHECK_EN adds fb_q/err bank compare
module jk_drive_counter #(
  parameter int WIDTH = 4,
  parameter int MODULO = 10,
  parameter bit ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
`ifdef JK_SELFCHECK_EN
  input  logic [WIDTH-1:0] fb_q,
  output logic             err,
`endif
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic load_fire, wrap;
  logic [WIDTH-1:0] target, clip;
  assign clip = load_data > MAX ? MAX : load_data;
  assign qn = ~q;
  always_comb begin
    load_ready = !rst && state != RUN;
    load_fire = load_valid && load_ready;
    wrap = 1'b0;
    target = q;
    state_n = state;
    case (state)
      IDLE: begin
        target = load_fire ? clip : q;
        state_n = !load_fire && en ? RUN : IDLE;
      end
      RUN: begin
        wrap = en && (up ? q == MAX : q == '0);
        target = !en ? q : up ? (wrap ? '0 : q + 1'b1) : (wrap ? MAX : q - 1'b1);
        state_n = !en ? IDLE : wrap && ONESHOT ? DONE : RUN;
      end
      DONE: begin
        target = load_fire ? clip : q;
        state_n = load_fire || !en ? IDLE : DONE;
      end
      default: state_n = IDLE;
    endcase
    // reset forces clear drive so an external bank clears on the same edge
    j = rst ? '0 : ~q & target;
    k = rst ? '1 : q & ~target;
  end
  always_ff @(posedge clk) begin
    q <= (j & ~q) | (~k & q);
    state <= rst ? IDLE : state_n;
    tc <= !rst && wrap;
  end
`ifdef JK_SELFCHECK_EN
  always_ff @(posedge clk) err <= rst ? 1'b0 : err | (fb_q != q);
`endif
endmodule
